// File: rtl/sata_dcr_regfile.sv
// rtl/sata_dcr_regfile.sv - multi-port DCR register file with per-port irq and DMA command queue
//
// Optional feature macro: SATA_DCR_IRQ_COAL_EN (dma-done interrupt coalescing by count/timeout).
//
// Ports:
//   sys_clk, sys_rst          single clock, synchronous active-high reset
//   address, write, writedata DCR access; readdata is registered (1-cycle read latency)
//   irq                       registered OR of every port's masked interrupt status
//   linkup, plllock           per-port asynchronous status, synchronized internally
//   error_code                per-port 4-bit error code (sys_clk domain)
//   rxfifo_irq, cxfifo_irq    per-port level interrupts
//   dma_req, dma_ack          per-port command queue head valid / pop
//   dma_address/length/flags  per-port command queue head fields

module sata_dcr_regfile #(
    parameter int C_NUM_PORTS = 2,
    parameter int C_CMD_DEPTH = 4,
    parameter int C_ADDR_W    = 6,
    parameter int C_COAL_CNT  = 4,
    parameter int C_COAL_TMO  = 1024
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [C_ADDR_W-1:0]        address,
    input  logic                       write,
    input  logic [31:0]                writedata,
    output logic [31:0]                readdata,
    output logic                       irq,
    input  logic [C_NUM_PORTS-1:0]     linkup,
    input  logic [C_NUM_PORTS-1:0]     plllock,
    input  logic [4*C_NUM_PORTS-1:0]   error_code,
    input  logic [C_NUM_PORTS-1:0]     rxfifo_irq,
    input  logic [C_NUM_PORTS-1:0]     cxfifo_irq,
    output logic [C_NUM_PORTS-1:0]     dma_req,
    input  logic [C_NUM_PORTS-1:0]     dma_ack,
    output logic [32*C_NUM_PORTS-1:0]  dma_address,
    output logic [16*C_NUM_PORTS-1:0]  dma_length,
    output logic [8*C_NUM_PORTS-1:0]   dma_flags
);

    localparam int PW = C_ADDR_W - 3;
    localparam int QW = $clog2(C_CMD_DEPTH);
    localparam int CW = QW + 1;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_IRQ_STAT = 3'd1;
    localparam logic [2:0] REG_IRQ_EN   = 3'd2;
    localparam logic [2:0] REG_DMA_CTRL = 3'd3;
    localparam logic [2:0] REG_DMA_ADDR = 3'd4;

    // Only W1C-capable bits of IRQ_STAT; [3:2] are live levels.
    localparam logic [5:0] STICKY_MASK = 6'b110011;

    logic [PW-1:0] port_idx;
    logic [2:0]    reg_idx;
    assign port_idx = address[C_ADDR_W-1:3];
    assign reg_idx  = address[2:0];

    logic unused_wd;
    assign unused_wd = ^{writedata[31], writedata[29:24]};

    logic [31:0] status_a   [C_NUM_PORTS];
    logic [5:0]  stat_view_a[C_NUM_PORTS];
    logic [5:0]  irq_en_a   [C_NUM_PORTS];
    logic [31:0] dma_addr_a [C_NUM_PORTS];
    logic [C_NUM_PORTS-1:0] port_irq;

    genvar g;
    generate
        for (g = 0; g < C_NUM_PORTS; g++) begin : g_port
            logic sel;
            logic wr_stat, wr_en, wr_ctrl, wr_addr;

            assign sel     = write && (port_idx == PW'(g));
            assign wr_stat = sel && (reg_idx == REG_IRQ_STAT);
            assign wr_en   = sel && (reg_idx == REG_IRQ_EN);
            assign wr_ctrl = sel && (reg_idx == REG_DMA_CTRL);
            assign wr_addr = sel && (reg_idx == REG_DMA_ADDR);

            // linkup/plllock: flops 0,1 synchronize; flop 2 delays flop 1 for edge detection.
            logic [2:0] lu_sync, pl_sync;
            logic       lu_edge, pl_edge;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    lu_sync <= '0;
                    pl_sync <= '0;
                end else begin
                    lu_sync <= {lu_sync[1:0], linkup[g]};
                    pl_sync <= {pl_sync[1:0], plllock[g]};
                end
            end

            assign lu_edge = lu_sync[1] ^ lu_sync[2];
            assign pl_edge = pl_sync[1] ^ pl_sync[2];

            // Command queue: entry = {address[31:0], length[15:0], flags[7:0]}.
            logic [55:0]   mem [C_CMD_DEPTH];
            logic [QW-1:0] wr_ptr, rd_ptr;
            logic [CW-1:0] q_cnt;
            logic          q_full, q_empty, pop, push_req, push, ovf;
            logic [55:0]   head;

            assign q_full   = (q_cnt == CW'(C_CMD_DEPTH));
            assign q_empty  = (q_cnt == '0);
            assign pop      = dma_ack[g] && !q_empty;
            assign push_req = wr_ctrl && writedata[30];
            // A simultaneous pop frees the slot the push lands in, so a full queue still accepts.
            assign push     = push_req && (!q_full || pop);
            assign ovf      = push_req && !push;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    q_cnt  <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + QW'(1);
                    if (pop)  rd_ptr <= rd_ptr + QW'(1);
                    case ({push, pop})
                        2'b10:   q_cnt <= q_cnt + CW'(1);
                        2'b01:   q_cnt <= q_cnt - CW'(1);
                        default: q_cnt <= q_cnt;
                    endcase
                end
            end

            always_ff @(posedge sys_clk) begin
                if (push) mem[wr_ptr] <= {dma_addr_a[g], writedata[15:0], writedata[23:16]};
            end

            assign head = mem[rd_ptr];
            assign dma_req[g]             = !q_empty;
            assign dma_address[32*g +: 32] = q_empty ? 32'd0 : head[55:24];
            assign dma_length[16*g +: 16]  = q_empty ? 16'd0 : head[23:8];
            assign dma_flags[8*g +: 8]     = q_empty ? 8'd0  : head[7:0];

            // DMA-done event generation.
            logic done_set;
`ifdef SATA_DCR_IRQ_COAL_EN
            localparam int CCW = $clog2(C_COAL_CNT + 1);
            localparam int TW  = $clog2(C_COAL_TMO + 1);
            logic [CCW-1:0] coal_cnt, cnt_nxt;
            logic [TW-1:0]  coal_tmr, tmr_nxt;
            logic           pending;

            always_comb begin
                cnt_nxt  = coal_cnt + CCW'(pop);
                pending  = (coal_cnt != '0);
                // Timer runs only while at least one ack is waiting to be reported.
                tmr_nxt  = pending ? coal_tmr + TW'(1) : '0;
                done_set = (cnt_nxt == CCW'(C_COAL_CNT)) || (tmr_nxt == TW'(C_COAL_TMO));
            end

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    coal_cnt <= '0;
                    coal_tmr <= '0;
                end else if (done_set) begin
                    coal_cnt <= '0;
                    coal_tmr <= '0;
                end else begin
                    coal_cnt <= cnt_nxt;
                    coal_tmr <= tmr_nxt;
                end
            end
`else
            assign done_set = pop;
`endif

            // Sticky status; a set in the same cycle as a W1C clear wins.
            logic [5:0] stat_r, set_v, clr_v;
            logic [5:0] irq_en_r;
            logic [31:0] dma_addr_r;

            assign set_v = {ovf, done_set, 2'b00, pl_edge, lu_edge};
            assign clr_v = wr_stat ? (writedata[5:0] & STICKY_MASK) : 6'd0;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    stat_r     <= '0;
                    irq_en_r   <= '0;
                    dma_addr_r <= '0;
                end else begin
                    stat_r <= (stat_r & ~clr_v) | set_v;
                    if (wr_en)   irq_en_r   <= writedata[5:0];
                    if (wr_addr) dma_addr_r <= writedata;
                end
            end

            assign stat_view_a[g] = {stat_r[5:4], cxfifo_irq[g], rxfifo_irq[g], stat_r[1:0]};
            assign irq_en_a[g]    = irq_en_r;
            assign dma_addr_a[g]  = dma_addr_r;
            assign status_a[g]    = {lu_sync[1], pl_sync[1], 14'd0, error_code[4*g +: 4],
                                     7'd0, 5'(q_cnt)};
            assign port_irq[g]    = |(stat_view_a[g] & irq_en_r);
        end
    endgenerate

    logic [31:0] rd_mux;

    // Port indices beyond C_NUM_PORTS never match, so they read as 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (32'(port_idx) == 32'(i)) begin
                case (reg_idx)
                    REG_STATUS:   rd_mux = status_a[i];
                    REG_IRQ_STAT: rd_mux = {26'd0, stat_view_a[i]};
                    REG_IRQ_EN:   rd_mux = {26'd0, irq_en_a[i]};
                    REG_DMA_ADDR: rd_mux = dma_addr_a[i];
                    default:      rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= |port_irq;
        end
    end

endmodule
